// File: rtl/lh_pkg.sv
// ---------------------------------------------------------------------------
// lh_pkg
// Shared definitions for the light-hash byte protocol sender.
//   lh_state_t  : encoding of the hash core's 2-bit state input
//   fsm_state_t : sender sequencing FSM states
//   LH_IV       : hash initial value, loaded by the core on a HEAD cycle
//   LH_FIFO_W   : width of one buffered input entry, {last, byte}
// ---------------------------------------------------------------------------
package lh_pkg;

    typedef enum logic [1:0] {
        LH_HEAD = 2'b00,
        LH_TAIL = 2'b01,
        LH_MSG  = 2'b10,
        LH_IDLE = 2'b11
    } lh_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_MSG,
        S_TAIL,
        S_WAIT_DG,
        S_OUT
    } fsm_state_t;

    localparam logic [63:0] LH_IV = 64'h34550F14DAC02BEE;

    localparam int LH_FIFO_W = 9;

endpackage

// File: rtl/lh_byte_fifo.sv
// ---------------------------------------------------------------------------
// lh_byte_fifo
// Synchronous show-ahead FIFO: rd_data always shows the oldest entry while
// empty is low; rd_en consumes it. full/empty are registered flags derived
// from the next occupancy, so they are exact in the cycle after each edge.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push (ignored while full)
//   rd_en, rd_data    pop (ignored while empty), head-of-queue data
//   full, empty       occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module lh_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    logic             full_reg, empty_reg;
    logic             wr_fire, rd_fire;

    assign wr_fire = wr_en & ~full_reg;
    assign rd_fire = rd_en & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        if (wr_fire && !rd_fire) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (rd_fire && !wr_fire) begin
            count_next = count_reg - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (wr_fire) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_fire) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == (AW+1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // Storage has no reset; stale contents are never visible because the
    // pointers and flags are reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = full_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/lh_msg_sender.sv
// ---------------------------------------------------------------------------
// lh_msg_sender
// Upstream end of the light-hash byte protocol. Buffers framed bytes from a
// valid/ready source, sequences them into the hash core as HEAD, MSG...,
// TAIL, then captures the digest and offers it on a valid/ready port.
// One message in flight at a time.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_byte/in_valid/in_last/in_ready   framed byte source
//   lh_message_byte/_valid, lh_state    drive the hash core
//   lh_digest, lh_digest_ready          result from the hash core
//   out_digest/out_len/out_err          captured result
//   out_valid/out_ready                 result handshake
//   busy                                FSM not idle
// Build option: define LH_TX_TIMEOUT_EN to bound the digest wait to
// TIMEOUT_CYCLES cycles; on expiry the result reports out_err=1, digest 0.
// ---------------------------------------------------------------------------
module lh_msg_sender
    import lh_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       lh_message_byte,
    output logic             lh_message_valid,
    output logic [1:0]       lh_state,
    input  logic [63:0]      lh_digest,
    input  logic             lh_digest_ready,
    output logic [63:0]      out_digest,
    output logic [LEN_W-1:0] out_len,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    fsm_state_t           state_reg, state_next;
    logic                 armed_reg;
    logic [7:0]           msg_byte_reg, msg_byte_next;
    logic                 msg_valid_reg, msg_valid_next;
    lh_state_t            lh_state_reg, lh_state_next;
    logic [LEN_W-1:0]     len_reg, len_next;
    logic [63:0]          out_digest_reg, out_digest_next;
    logic [LEN_W-1:0]     out_len_reg, out_len_next;
    logic                 out_err_reg, out_err_next;
    logic                 out_valid_reg, out_valid_next;
    logic                 busy_reg;

    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [LH_FIFO_W-1:0] fifo_head;

`ifdef LH_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_reg, tmo_next;
`endif

    // armed_reg keeps in_ready low until the first edge after reset release.
    assign in_ready  = armed_reg & ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    assign fifo_pop  = (state_reg == S_MSG) & ~fifo_empty;

    lh_byte_fifo #(
        .WIDTH (LH_FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_push),
        .wr_data ({in_last, in_byte}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Outputs are computed from the current state and registered on the same
    // edge that advances the FSM, so each state's action appears one cycle
    // after that state is entered.
    always_comb begin
        state_next      = state_reg;
        msg_byte_next   = msg_byte_reg;
        msg_valid_next  = 1'b0;
        lh_state_next   = LH_IDLE;
        len_next        = len_reg;
        out_digest_next = out_digest_reg;
        out_len_next    = out_len_reg;
        out_err_next    = out_err_reg;
        out_valid_next  = out_valid_reg;
`ifdef LH_TX_TIMEOUT_EN
        tmo_next        = tmo_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) state_next = S_HEAD;
            end
            S_HEAD: begin
                msg_valid_next = 1'b1;
                lh_state_next  = LH_HEAD;
                len_next       = '0;
                state_next     = S_MSG;
            end
            S_MSG: begin
                // An empty FIFO here is a source stall: idle cycles are
                // ignored by the core, so just hold valid low.
                lh_state_next = LH_MSG;
                if (!fifo_empty) begin
                    msg_valid_next = 1'b1;
                    msg_byte_next  = fifo_head[7:0];
                    if (len_reg != '1) len_next = len_reg + LEN_W'(1);
                    if (fifo_head[8]) state_next = S_TAIL;
                end
            end
            S_TAIL: begin
                msg_valid_next = 1'b1;
                lh_state_next  = LH_TAIL;
                state_next     = S_WAIT_DG;
`ifdef LH_TX_TIMEOUT_EN
                tmo_next       = '0;
`endif
            end
            S_WAIT_DG: begin
                if (lh_digest_ready) begin
                    out_digest_next = lh_digest;
                    out_len_next    = len_reg;
                    out_err_next    = 1'b0;
                    out_valid_next  = 1'b1;
                    state_next      = S_OUT;
                end
`ifdef LH_TX_TIMEOUT_EN
                else if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    out_digest_next = '0;
                    out_len_next    = len_reg;
                    out_err_next    = 1'b1;
                    out_valid_next  = 1'b1;
                    state_next      = S_OUT;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
`endif
            end
            S_OUT: begin
                if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            armed_reg      <= 1'b0;
            msg_byte_reg   <= '0;
            msg_valid_reg  <= 1'b0;
            lh_state_reg   <= LH_IDLE;
            len_reg        <= '0;
            out_digest_reg <= '0;
            out_len_reg    <= '0;
            out_err_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef LH_TX_TIMEOUT_EN
            tmo_reg        <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            armed_reg      <= 1'b1;
            msg_byte_reg   <= msg_byte_next;
            msg_valid_reg  <= msg_valid_next;
            lh_state_reg   <= lh_state_next;
            len_reg        <= len_next;
            out_digest_reg <= out_digest_next;
            out_len_reg    <= out_len_next;
            out_err_reg    <= out_err_next;
            out_valid_reg  <= out_valid_next;
            busy_reg       <= (state_next != S_IDLE);
`ifdef LH_TX_TIMEOUT_EN
            tmo_reg        <= tmo_next;
`endif
        end
    end

    assign lh_message_byte  = msg_byte_reg;
    assign lh_message_valid = msg_valid_reg;
    assign lh_state         = lh_state_reg;
    assign out_digest       = out_digest_reg;
    assign out_len          = out_len_reg;
    assign out_err          = out_err_reg;
    assign out_valid        = out_valid_reg;
    assign busy             = busy_reg;

endmodule

// File: tb/tb_lh_msg_sender.sv
// ---------------------------------------------------------------------------
// tb_lh_msg_sender
// Directed bench for lh_msg_sender with a behavioural light_hash stand-in
// and a golden hash model. Expected results are queued when a message is
// issued; a monitor pops and compares on every out_valid&out_ready.
// Define LH_TX_TIMEOUT_EN to also exercise the digest timeout.
// ---------------------------------------------------------------------------
module tb_lh_msg_sender;
    import lh_pkg::*;

    localparam int LEN_W = 16;
    localparam int TMO   = 64;

    typedef struct packed {
        logic [63:0]      dg;
        logic [LEN_W-1:0] len;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       in_byte = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [7:0]       lh_message_byte;
    logic             lh_message_valid;
    logic [1:0]       lh_state;
    logic [63:0]      lh_digest = 64'h0;
    logic             lh_digest_ready = 1'b0;
    logic [63:0]      out_digest;
    logic [LEN_W-1:0] out_len;
    logic             out_err;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             busy;

    always #5 clk = ~clk;

    lh_msg_sender #(
        .FIFO_DEPTH     (16),
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_byte          (in_byte),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .lh_message_byte  (lh_message_byte),
        .lh_message_valid (lh_message_valid),
        .lh_state         (lh_state),
        .lh_digest        (lh_digest),
        .lh_digest_ready  (lh_digest_ready),
        .out_digest       (out_digest),
        .out_len          (out_len),
        .out_err          (out_err),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc = 0;
    exp_t       sb_q[$];
    logic [7:0] msg_q[$];
    logic [1:0] seq_q[$];
    int         gap_cnt = 0;
    int         first_msg_cyc = -1;
    int         tail_cyc = 0;
    int         acc_cnt = 0;
    int         last_acc_cyc = 0;
    int         first_acc_cyc = 0;
    bit         stub_mute = 1'b0;

    function automatic logic [63:0] lh_mix(input logic [63:0] h, input logic [7:0] b);
        return ({h[55:0], h[63:56]} ^ {56'd0, b}) * 64'h0000_0100_0000_01B3;
    endfunction

    function automatic logic [63:0] lh_fin(input logic [63:0] h);
        return h ^ {h[31:0], h[63:32]} ^ 64'h0000_0000_0000_00A5;
    endfunction

    function automatic logic [63:0] golden();
        logic [63:0] h;
        h = LH_IV;
        foreach (msg_q[i]) h = lh_mix(h, msg_q[i]);
        return lh_fin(h);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last);
        int w;
        w = 0;
        in_byte  = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && w < 300) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL push_timeout: got in_ready=0 expected 1 within 300 cycles");
        end
        tick();
        in_valid     = 1'b0;
        in_last      = 1'b0;
        acc_cnt      = acc_cnt + 1;
        last_acc_cyc = cyc;
    endtask

    // Queues the expected result, then pushes msg_q, optionally stalling
    // stall_n cycles before byte index stall_at.
    task automatic send_msg(input int stall_at, input int stall_n, input bit exp_err);
        exp_t e;
        e.dg  = exp_err ? 64'h0 : golden();
        e.len = LEN_W'(msg_q.size());
        e.err = exp_err;
        sb_q.push_back(e);
        for (int i = 0; i < msg_q.size(); i++) begin
            if (i == stall_at) repeat (stall_n) tick();
            push_byte(msg_q[i], i == msg_q.size() - 1);
            if (i == 0) first_acc_cyc = last_acc_cyc;
        end
    endtask

    task automatic wait_done(input string name);
        int w;
        w = 0;
        while ((sb_q.size() != 0 || busy) && w < 1000) begin
            tick();
            w++;
        end
        check(name, 64'(w < 1000), 64'd1);
    endtask

    function automatic logic [9:0] seq_pack(input int start);
        logic [9:0] p;
        p = '0;
        for (int i = 0; i < 5; i++) begin
            if (start + i < seq_q.size()) p = {p[7:0], seq_q[start + i]};
        end
        return p;
    endfunction

    initial begin
        int s0, g0, a0;

        fork
            // cycle counter
            forever begin
                @(posedge clk);
                cyc = cyc + 1;
            end
            // light_hash stand-in: consumes the byte protocol, returns the
            // digest three cycles after TAIL unless muted
            begin
                logic [63:0] h;
                int cd;
                bit in_msg;
                h = 64'h0; cd = 0; in_msg = 1'b0;
                forever begin
                    @(negedge clk);
                    lh_digest_ready = 1'b0;
                    if (!rst_n) begin
                        cd = 0;
                        in_msg = 1'b0;
                    end else begin
                        if (cd > 0) begin
                            cd--;
                            if (cd == 0) begin
                                lh_digest_ready = 1'b1;
                                lh_digest       = h;
                            end
                        end
                        if (lh_message_valid) begin
                            seq_q.push_back(lh_state);
                            case (lh_state)
                                2'b00: begin
                                    h = LH_IV;
                                    in_msg = 1'b1;
                                    first_msg_cyc = -1;
                                end
                                2'b10: begin
                                    h = lh_mix(h, lh_message_byte);
                                    if (first_msg_cyc < 0) first_msg_cyc = cyc;
                                end
                                2'b01: begin
                                    h = lh_fin(h);
                                    in_msg = 1'b0;
                                    tail_cyc = cyc;
                                    if (!stub_mute) cd = 3;
                                end
                                default: ;
                            endcase
                        end else if (in_msg) begin
                            gap_cnt = gap_cnt + 1;
                        end
                    end
                end
            end
            // result monitor / scoreboard
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    $display("[TB] result digest=%h len=%0d err=%0b", out_digest, out_len, out_err);
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_result: got digest %h expected no result", out_digest);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_digest", out_digest, e.dg);
                        check("out_len", 64'(out_len), 64'(e.len));
                        check("out_err", 64'(out_err), 64'(e.err));
                    end
                end
            end
        join_none

        // ---- reset state
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_msg_valid", 64'(lh_message_valid), 64'd0);
        check("rst_lh_state", 64'(lh_state), 64'd3);
        check("rst_msg_byte", 64'(lh_message_byte), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_digest", out_digest, 64'd0);
        check("rst_out_len", 64'(out_len), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("in_ready_after_release", 64'(in_ready), 64'd1);

        // ---- 1: "abc"
        $display("[TB] scenario 1: abc");
        s0 = seq_q.size(); g0 = gap_cnt;
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(-1, 0, 1'b0);
        wait_done("s1_drain");
        check("s1_state_seq", 64'(seq_pack(s0)), 64'(10'b00_10_10_10_01));
        check("s1_seq_len", 64'(seq_q.size() - s0), 64'd5);
        check("s1_latency", 64'(first_msg_cyc - first_acc_cyc), 64'd3);
        check("s1_no_gap", 64'(gap_cnt - g0), 64'd0);

        // ---- 2: single zero byte
        $display("[TB] scenario 2: single byte 00");
        msg_q = '{8'h00};
        send_msg(-1, 0, 1'b0);
        wait_done("s2_drain");

        // ---- 3: source stall between bytes 2 and 3
        $display("[TB] scenario 3: abc with 5-cycle stall");
        s0 = seq_q.size(); g0 = gap_cnt;
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(2, 5, 1'b0);
        wait_done("s3_drain");
        check("s3_state_seq", 64'(seq_pack(s0)), 64'(10'b00_10_10_10_01));
        check("s3_gap_cycles", 64'(gap_cnt - g0), 64'd3);

        // ---- 4: backpressure on the result port
        $display("[TB] scenario 4: out_ready low, 2 + 18 bytes");
        out_ready = 1'b0;
        msg_q = '{8'h10, 8'h11};
        send_msg(-1, 0, 1'b0);
        msg_q.delete();
        for (int i = 0; i < 18; i++) msg_q.push_back(8'(8'h20 + i));
        a0 = acc_cnt;
        fork
            send_msg(-1, 0, 1'b0);
            begin
                repeat (40) tick();
                check("s4_in_ready_low", 64'(in_ready), 64'd0);
                check("s4_buffered", 64'(acc_cnt - a0), 64'd16);
                check("s4_out_valid_held", 64'(out_valid), 64'd1);
                check("s4_busy", 64'(busy), 64'd1);
                out_ready = 1'b1;
            end
        join
        wait_done("s4_drain");

        // ---- 5: reset in the middle of a message
        $display("[TB] scenario 5: reset mid-message");
        push_byte(8'hA0, 1'b0);
        push_byte(8'hA1, 1'b0);
        repeat (6) tick();
        check("s5_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_msg_valid", 64'(lh_message_valid), 64'd0);
        check("s5_rst_lh_state", 64'(lh_state), 64'd3);
        check("s5_rst_in_ready", 64'(in_ready), 64'd0);
        check("s5_rst_busy", 64'(busy), 64'd0);
        check("s5_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("s5_fifo_flushed", 64'(busy), 64'd0);
        check("s5_in_ready", 64'(in_ready), 64'd1);
        msg_q = '{8'h5A, 8'hC3};
        send_msg(-1, 0, 1'b0);
        wait_done("s5_drain");

`ifdef LH_TX_TIMEOUT_EN
        // ---- 6: core never answers
        begin
            int w;
            $display("[TB] scenario 6: digest timeout");
            stub_mute = 1'b1;
            msg_q = '{8'h77};
            send_msg(-1, 0, 1'b1);
            w = 0;
            while (!out_valid && w < 300) begin
                tick();
                w++;
            end
            check("s6_timeout_cycles", 64'(cyc - tail_cyc), 64'(TMO));
            wait_done("s6_drain");
            stub_mute = 1'b0;
        end
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog: the run must always end on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
